// File: rtl/rah_tx_arbiter.sv
// Round-robin transmit scheduler: frames each grant as a header word {app id, len}
// followed by len payload words popped from the granted app's FWFT queue.
module rah_tx_arbiter #(
    parameter int DATA_WIDTH   = 48,
    parameter int TOTAL_APPS   = 4,
    parameter int APP_ID_WIDTH = 4,
    parameter int LEVEL_WIDTH  = 10,
    parameter int MAX_BURST    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TOTAL_APPS*LEVEL_WIDTH-1:0] app_level,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0]  app_rd_data,
    output logic [TOTAL_APPS-1:0]             app_rd_en,
    output logic [DATA_WIDTH-1:0]             tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              tx_last,
    output logic [APP_ID_WIDTH-1:0]           grant_id,
    output logic                              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [APP_ID_WIDTH-1:0] r_last_grant;
    logic [APP_ID_WIDTH-1:0] r_grant_id;
    logic [LEVEL_WIDTH-1:0]  r_len;
    logic [LEVEL_WIDTH-1:0]  r_count;

    logic [TOTAL_APPS-1:0]   w_req;
    logic                    w_any;
    logic                    w_high_found;
    logic [APP_ID_WIDTH-1:0] w_low;
    logic [APP_ID_WIDTH-1:0] w_high;
    logic [APP_ID_WIDTH-1:0] w_winner;
    logic [LEVEL_WIDTH-1:0]  w_win_level;
    logic [LEVEL_WIDTH-1:0]  w_win_len;
    logic [LEVEL_WIDTH-1:0]  w_grant_level;
    logic [DATA_WIDTH-1:0]   w_grant_data;
    logic [DATA_WIDTH-1:0]   w_header;
    logic [LEVEL_WIDTH-1:0]  w_last_idx;
    logic                    w_xfer;
    logic                    w_is_last;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_req = '0;
        for (int i = 0; i < TOTAL_APPS; i++) begin
            w_req[i] = |app_level[i*LEVEL_WIDTH +: LEVEL_WIDTH];
        end
    end

    // Round robin: lowest requester above last_grant wins, else lowest requester overall.
    always_comb begin
        w_any        = 1'b0;
        w_high_found = 1'b0;
        w_low        = '0;
        w_high       = '0;
        for (int i = TOTAL_APPS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_any = 1'b1;
                w_low = APP_ID_WIDTH'(i);
                if (i > int'(r_last_grant)) begin
                    w_high_found = 1'b1;
                    w_high       = APP_ID_WIDTH'(i);
                end
            end
        end
        w_winner = w_high_found ? w_high : w_low;
    end

    always_comb begin
        w_win_level   = '0;
        w_grant_level = '0;
        w_grant_data  = '0;
        for (int i = 0; i < TOTAL_APPS; i++) begin
            if (w_winner == APP_ID_WIDTH'(i)) begin
                w_win_level = app_level[i*LEVEL_WIDTH +: LEVEL_WIDTH];
            end
            if (r_grant_id == APP_ID_WIDTH'(i)) begin
                w_grant_level = app_level[i*LEVEL_WIDTH +: LEVEL_WIDTH];
                w_grant_data  = app_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_win_len = (w_win_level > LEVEL_WIDTH'(MAX_BURST)) ? LEVEL_WIDTH'(MAX_BURST) : w_win_level;
    end

    always_comb begin
        w_header                                 = '0;
        w_header[DATA_WIDTH-1 -: APP_ID_WIDTH]   = r_grant_id;
        w_header[LEVEL_WIDTH-1:0]                = r_len;
        w_last_idx                               = r_len - LEVEL_WIDTH'(1);
    end

    // Handshake outputs are combinational so a level drop mid-burst stalls without a pop.
    always_comb begin
        w_next_state = r_state;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_last      = 1'b0;
        app_rd_en    = '0;
        w_xfer       = 1'b0;
        w_is_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_state = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = w_header;
                w_xfer   = tx_ready;
                if (tx_ready) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                tx_valid  = |w_grant_level;
                tx_data   = w_grant_data;
                w_xfer    = tx_valid & tx_ready;
                w_is_last = (r_count == w_last_idx);
                tx_last   = w_is_last & tx_valid;
                for (int i = 0; i < TOTAL_APPS; i++) begin
                    if (r_grant_id == APP_ID_WIDTH'(i)) begin
                        app_rd_en[i] = w_xfer;
                    end
                end
                if (w_xfer && w_is_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: only control registers need reset; last_grant starts at the top so app 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= APP_ID_WIDTH'(TOTAL_APPS - 1);
            r_grant_id   <= '0;
            r_len        <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_len        <= w_win_len;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_count <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        if (w_is_last) begin
                            r_grant_id <= '0;
                            r_count    <= '0;
                        end else begin
                            r_count <= r_count + LEVEL_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rah_tx_arbiter.sv
// Self-checking bench for rah_tx_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based transaction model of the scheduler.
module tb_rah_tx_arbiter;

    localparam int DW = 48;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int LW = 10;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*LW-1:0] app_level;
    logic [N*DW-1:0] app_rd_data;
    logic [N-1:0]    app_rd_en;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            tx_last;
    logic [IW-1:0]   grant_id;
    logic            busy;

    always #5 clk = ~clk;

    rah_tx_arbiter #(
        .DATA_WIDTH  (DW),
        .TOTAL_APPS  (N),
        .APP_ID_WIDTH(IW),
        .LEVEL_WIDTH (LW),
        .MAX_BURST   (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .app_level  (app_level),
        .app_rd_data(app_rd_data),
        .app_rd_en  (app_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] q[N][$];
    bit            force_zero[N];
    bit            rdy_pat[$];
    bit            rdy_random = 1'b0;
    bit            bg_push = 1'b0;
    int            cur_id = 0;
    int            exp_last = N - 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    task automatic drive_apps();
        for (int i = 0; i < N; i++) begin
            int sz;
            sz = q[i].size();
            app_level[i*LW +: LW]   = force_zero[i] ? '0 : LW'(sz);
            app_rd_data[i*DW +: DW] = (sz > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push_words(input int app, input int n);
        for (int k = 0; k < n; k++) q[app].push_back(rand_word());
        drive_apps();
        #1;
    endtask

    function automatic bit next_ready();
        if (rdy_pat.size() > 0) return rdy_pat.pop_front();
        if (rdy_random) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Expected winner: first non-empty queue after the previous grant, wrapping.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) begin
            int a;
            a = (last + k) % N;
            if (q[a].size() > 0) return a;
        end
        return -1;
    endfunction

    // One clock: record the pops seen before the edge, then apply them to the queues.
    task automatic tick();
        logic [N-1:0] pops;
        pops = app_rd_en;
        check("rd_en_onehot", 64'($countones(pops) <= 1), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pops[i]) begin
                check("pop_nonempty", 64'(q[i].size() > 0), 64'd1);
                if (q[i].size() > 0) void'(q[i].pop_front());
            end
        end
        if (bg_push && $urandom_range(0, 5) == 0) begin
            int a;
            a = $urandom_range(0, N - 1);
            if (a != cur_id) q[a].push_back(rand_word());
        end
        drive_apps();
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"}, tx_valid, 0);
        check({pfx, "_data"}, tx_data, 0);
        check({pfx, "_last"}, tx_last, 0);
        check({pfx, "_grant"}, grant_id, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_rd_en"}, app_rd_en, 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            force_zero[i] = 1'b0;
        end
        drive_apps();
        #1;
        check_all_zero("rst");
        tick();
        tick();
        rst_n    = 1'b1;
        exp_last = N - 1;
        #1;
    endtask

    // Expect one full frame for app id with len payload words. stall_at forces the level
    // to zero for two cycles before that payload index; abort_at asserts reset there.
    task automatic run_frame(input int id, input int len, input int stall_at, input int abort_at);
        logic [DW-1:0] words[$];
        logic [DW-1:0] hdr;
        int            waited;
        cur_id = id;
        hdr = '0;
        hdr[DW-1 -: IW] = IW'(id);
        hdr[LW-1:0]     = LW'(len);
        words.push_back(hdr);
        for (int k = 0; k < len; k++) words.push_back(q[id][k]);
        waited = 0;
        while (!tx_valid && waited < 8) begin
            tick();
            waited++;
        end
        check("hdr_latency", waited, 1);
        for (int idx = 0; idx <= len; idx++) begin
            int guard;
            guard = 0;
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                return;
            end
            if (idx == stall_at) begin
                force_zero[id] = 1'b1;
                drive_apps();
                #1;
                repeat (2) begin
                    check("stall_valid", tx_valid, 0);
                    check("stall_pop", app_rd_en, 0);
                    check("stall_busy", busy, 1);
                    tick();
                end
                force_zero[id] = 1'b0;
                drive_apps();
                #1;
            end
            forever begin
                bit rdy;
                rdy = next_ready();
                tx_ready = rdy;
                #1;
                check("valid", tx_valid, 1);
                check("data", tx_data, words[idx]);
                check("last", tx_last, 64'(idx == len));
                check("grant", grant_id, id);
                check("busy", busy, 1);
                check("rd_en", app_rd_en, (rdy && idx > 0) ? (64'd1 << id) : 64'd0);
                tick();
                guard++;
                if (rdy) break;
                if (guard > 40) begin
                    check("ready_guard", guard, 0);
                    break;
                end
            end
        end
        check("idle_valid", tx_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant_id, 0);
        exp_last = id;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_ready = 1'b0;
        do_reset();

        // App 1 alone, level 3: one-cycle latency, three pops, last on the third word.
        push_words(1, 3);
        check("t1_pre_valid", tx_valid, 0);
        run_frame(1, 3, -1, -1);
        check("t1_drained", q[1].size(), 0);

        // Apps 0 and 2 held at level 2 alternate strictly.
        do_reset();
        push_words(0, 2);
        push_words(2, 2);
        for (int r = 0; r < 4; r++) begin
            int id;
            id = (r % 2 == 0) ? 0 : 2;
            run_frame(id, 2, -1, -1);
            push_words(id, 2);
        end

        // Level above MAX_BURST saturates len, remainder follows as a lone re-grant.
        do_reset();
        push_words(3, 20);
        run_frame(3, 16, -1, -1);
        run_frame(3, 4, -1, -1);

        // Backpressure mid-burst: ready 1,0,0,1 on the payload.
        push_words(2, 4);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        run_frame(2, 4, -1, -1);

        // Upstream underrun for two cycles before payload word 2.
        push_words(1, 5);
        run_frame(1, 5, 2, -1);
        check("t5_drained", q[1].size(), 0);

        // Reset after payload word 2 of 5, then app 0 wins with everyone requesting.
        push_words(0, 5);
        run_frame(0, 5, -1, 3);
        do_reset();
        for (int i = 0; i < N; i++) push_words(i, 3);
        run_frame(0, 3, -1, -1);

        // Randomized traffic against the round-robin model.
        rdy_random = 1'b1;
        bg_push    = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int id;
            int len;
            if ($urandom_range(0, 2) == 0 || rr_pick(exp_last) < 0) begin
                push_words($urandom_range(0, N - 1), $urandom_range(1, 20));
            end
            id  = rr_pick(exp_last);
            len = (q[id].size() > MB) ? MB : q[id].size();
            run_frame(id, len, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
